// File: rtl/det_pkg.sv
// Shared definitions for the detection-event logger.
// Holds the detector code constants, the code typedef, the default event
// record layout and the event-condition helper used by the logger top.
package det_pkg;

    localparam int CODE_W   = 2;
    localparam int TS_W_DEF = 16;

    typedef logic [CODE_W-1:0] det_code_t;

    localparam det_code_t CODE_NONE = 2'b00;
    localparam det_code_t CODE_1    = 2'b01;
    localparam det_code_t CODE_2    = 2'b10;
    localparam det_code_t CODE_3    = 2'b11;

    // Event record as stored in the FIFO for the default timestamp width:
    // code in the upper bits, timestamp in the lower bits.
    typedef struct packed {
        det_code_t             code;
        logic [TS_W_DEF-1:0]   ts;
    } ev_rec_t;

    // A detection is logged when a nonzero code differs from the previous one.
    function automatic logic is_event(input det_code_t code, input det_code_t prev);
        return (code != CODE_NONE) && (code != prev);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Ports: clk, rst (async active-low), clr (sync clear), push/din write side,
// pop/dout read side (dout valid whenever empty=0), full, empty, level.
// A pop and a push in the same cycle both succeed even when full.
module event_fifo #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign level = wr_ptr_r - rd_ptr_r;
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // Qualify requests: pops need data, pushes need room or a concurrent pop.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && (!full || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Pointer and storage update; clear also zeroes storage so dout is defined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clr) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/detect_event_logger.sv
// Detection event logger.
// Turns changes of the detector's 2-bit code into timestamped events,
// buffers them in a FWFT FIFO behind a valid/ready port, and keeps per-code
// saturating hit counters plus a sticky overflow flag.
// Ports: clk, rst (async active-low), clr (sync clear of all state),
// det_code in; ev_valid/ev_ready/ev_code/ev_time event port;
// cnt_c1..cnt_c3 hit counters; overflow sticky drop flag; level occupancy.
module detect_event_logger
    import det_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  det_code_t                det_code,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [CODE_W-1:0]        ev_code,
    output logic [TS_W-1:0]          ev_time,
    output logic [CNT_W-1:0]         cnt_c1,
    output logic [CNT_W-1:0]         cnt_c2,
    output logic [CNT_W-1:0]         cnt_c3,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int             REC_W   = CODE_W + TS_W;
    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0]  ts_r;
    det_code_t        prev_code_r;
    logic [CNT_W-1:0] cnt_c1_r;
    logic [CNT_W-1:0] cnt_c2_r;
    logic [CNT_W-1:0] cnt_c3_r;
    logic             overflow_r;

    logic             event_s;
    logic             pop_s;
    logic             drop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [REC_W-1:0] rec_in_s;
    logic [REC_W-1:0] rec_out_s;

    // Event and pop qualification; clear discards both in its cycle.
    always_comb begin
        event_s = 1'b0;
        pop_s   = 1'b0;
        drop_s  = 1'b0;
        if (clr) begin
            event_s = 1'b0;
            pop_s   = 1'b0;
            drop_s  = 1'b0;
        end else begin
            event_s = is_event(det_code, prev_code_r);
            pop_s   = ev_ready && !fifo_empty_s;
            // A pop in the same cycle frees the slot, so only full-without-pop drops.
            drop_s  = event_s && fifo_full_s && !pop_s;
        end
    end

    // Record carries the timestamp as it was before this edge's increment.
    assign rec_in_s = {det_code, ts_r};

    event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (event_s),
        .pop   (pop_s),
        .din   (rec_in_s),
        .dout  (rec_out_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (level)
    );

    assign ev_valid = !fifo_empty_s;
    assign ev_code  = rec_out_s[REC_W-1:TS_W];
    assign ev_time  = rec_out_s[TS_W-1:0];
    assign cnt_c1   = cnt_c1_r;
    assign cnt_c2   = cnt_c2_r;
    assign cnt_c3   = cnt_c3_r;
    assign overflow = overflow_r;

    // Free-running timestamp and code history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_r        <= {TS_W{1'b0}};
            prev_code_r <= CODE_NONE;
        end else if (clr) begin
            ts_r        <= {TS_W{1'b0}};
            prev_code_r <= CODE_NONE;
        end else begin
            ts_r        <= ts_r + TS_ONE;
            prev_code_r <= det_code;
        end
    end

    // Per-code saturating hit counters; dropped events still count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_c1_r <= {CNT_W{1'b0}};
            cnt_c2_r <= {CNT_W{1'b0}};
            cnt_c3_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_c1_r <= {CNT_W{1'b0}};
            cnt_c2_r <= {CNT_W{1'b0}};
            cnt_c3_r <= {CNT_W{1'b0}};
        end else if (event_s) begin
            case (det_code)
                CODE_1: begin
                    if (cnt_c1_r != CNT_MAX) cnt_c1_r <= cnt_c1_r + CNT_ONE;
                end
                CODE_2: begin
                    if (cnt_c2_r != CNT_MAX) cnt_c2_r <= cnt_c2_r + CNT_ONE;
                end
                CODE_3: begin
                    if (cnt_c3_r != CNT_MAX) cnt_c3_r <= cnt_c3_r + CNT_ONE;
                end
                default: begin
                    cnt_c1_r <= cnt_c1_r;
                end
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset or clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (clr) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_detect_event_logger.sv
// Scoreboard bench for detect_event_logger: a behavioural model pushes the
// expected event records into a queue, and a monitor compares the DUT's
// event port, occupancy, counters and overflow on every falling edge.
module tb_detect_event_logger;

    localparam int TS_W  = 6;
    localparam int DEPTH = 8;
    localparam int CNT_W = 3;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr = 1'b0;
    logic [1:0]        det_code = 2'b00;
    logic              ev_ready = 1'b0;
    logic              ev_valid;
    logic [1:0]        ev_code;
    logic [TS_W-1:0]   ev_time;
    logic [CNT_W-1:0]  cnt_c1, cnt_c2, cnt_c3;
    logic              overflow;
    logic [LW-1:0]     level;

    always #5 clk = ~clk;

    detect_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .det_code(det_code),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_time(ev_time),
        .cnt_c1(cnt_c1), .cnt_c2(cnt_c2), .cnt_c3(cnt_c3),
        .overflow(overflow), .level(level)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct { int code; int ts; } rec_t;
    rec_t exp_q[$];
    int   m_ts;
    int   m_prev;
    int   m_cnt [4];
    bit   m_ovf;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: logged events are those whose code is nonzero and
    // differs from last cycle's; they enter the queue if it has room.
    always @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            exp_q.delete();
            m_ts   <= 0;
            m_prev <= 0;
            m_ovf  <= 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
        end else begin
            if (det_code != 2'b00 && int'(det_code) != m_prev) begin
                if (m_cnt[det_code] < (1 << CNT_W) - 1) m_cnt[det_code] <= m_cnt[det_code] + 1;
                if (exp_q.size() < DEPTH) exp_q.push_back('{int'(det_code), m_ts});
                else m_ovf <= 1'b1;
            end
            m_prev <= int'(det_code);
            m_ts   <= (m_ts + 1) % (1 << TS_W);
        end
    end

    // Monitor: compare the presented state, and retire the head when the
    // handshake will complete at the coming rising edge.
    always @(negedge clk) begin
        if (rst) begin
            check("level",    level,    exp_q.size());
            check("ev_valid", ev_valid, int'(exp_q.size() != 0));
            check("cnt_c1",   cnt_c1,   m_cnt[1]);
            check("cnt_c2",   cnt_c2,   m_cnt[2]);
            check("cnt_c3",   cnt_c3,   m_cnt[3]);
            check("overflow", overflow, m_ovf);
            if (exp_q.size() != 0) begin
                check("ev_code", ev_code, exp_q[0].code);
                check("ev_time", ev_time, exp_q[0].ts);
                if (ev_valid && ev_ready && !clr) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int code, input bit rdy, input bit c);
        @(posedge clk);
        #1;
        det_code = code[1:0];
        ev_ready = rdy;
        clr      = c;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, ev_valid, 0);
        check({tag, "_code"},  ev_code,  0);
        check({tag, "_time"},  ev_time,  0);
        check({tag, "_level"}, level,    0);
        check({tag, "_c1"},    cnt_c1,   0);
        check({tag, "_c2"},    cnt_c2,   0);
        check({tag, "_c3"},    cnt_c3,   0);
        check({tag, "_ovf"},   overflow, 0);
    endtask

    int seq2 [7] = '{0, 1, 2, 2, 3, 0, 3};
    int code_r;
    int rdy_pct;

    initial begin
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Held code logs once, buffered with the consumer stalled.
        repeat (4) step(1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0);

        // Direct code changes with the consumer always ready.
        foreach (seq2[i]) step(seq2[i], 1'b1, 1'b0);
        repeat (3) step(0, 1'b1, 1'b0);

        // Nine events into an eight-deep buffer, then drain.
        step(0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step((i % 2) ? 2 : 1, 1'b0, 1'b0);
        repeat (2) step(0, 1'b0, 1'b0);
        repeat (10) step(0, 1'b1, 1'b0);

        // Full buffer, new event together with a pop.
        step(0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step((i % 2) ? 2 : 1, 1'b0, 1'b0);
        step(3, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0);

        // Clear while a code is held: history restarts, so it logs again.
        step(0, 1'b0, 1'b1);
        step(1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0);
        step(1, 1'b0, 1'b1);
        repeat (3) step(1, 1'b0, 1'b0);

        // Counter saturation.
        step(0, 1'b1, 1'b1);
        repeat (10) begin
            step(2, 1'b1, 1'b0);
            step(0, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of a drain.
        step(0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1 + (i % 3), 1'b0, 1'b0);
        step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b1;

        // Randomized traffic with varying consumer throughput.
        code_r  = 0;
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_pct = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 90);
            if ($urandom_range(0, 1) == 0) code_r = int'($urandom_range(0, 3));
            step(code_r, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 199) == 0));
        end
        repeat (12) step(0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
